// File: rtl/rot_shift_pkg.sv
`default_nettype none
// =============================================================================
// rot_shift_pkg : opcodes, FSM encoding and width shared by rot_shift_sched.
// Rev 1.0
// =============================================================================
package rot_shift_pkg;

   localparam int WIDTH = 32;
   localparam int OP_W  = 3;

   localparam logic [OP_W-1:0] OP_ROL  = 3'd0;
   localparam logic [OP_W-1:0] OP_ROR  = 3'd1;
   localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
   localparam logic [OP_W-1:0] OP_SHR  = 3'd3;
   localparam logic [OP_W-1:0] OP_SHRA = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rot_shift_sched_core.sv
`default_nettype none
// =============================================================================
// rot_core : combinational rotate-left; amount 0 is an identity.
// Rev 1.0
// =============================================================================
module rot_core #(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AMT_W-1:0] amt_i,
   output logic [WIDTH-1:0] data_o
);

   logic [2*WIDTH-1:0] w_dbl;

   // Upper half of the doubled word shifted left is the rotate-left result.
   assign w_dbl  = {data_i, data_i} << amt_i;
   assign data_o = w_dbl[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/rot_shift_sched.sv
`default_nettype none
// =============================================================================
// rot_shift_sched : two-requester arbiter/sequencer around one shared rotate core.
// Macro ROT_SHIFT_OPS_EN enables SHL/SHR/SHRA.                       Rev 1.0
// =============================================================================
module rot_shift_sched #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [OP_W-1:0]  r0_op,
   input  logic [WIDTH-1:0] r0_data,
   input  logic [WIDTH-1:0] r0_amt,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [OP_W-1:0]  r1_op,
   input  logic [WIDTH-1:0] r1_data,
   input  logic [WIDTH-1:0] r1_amt,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);
   import rot_shift_pkg::*;

   localparam int AMT_W = $clog2(WIDTH);

   state_e            state_q, state_d;
   logic              prio_q;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  data_q;
   logic [AMT_W-1:0]  amt_q;
   logic              id_q;
   logic [WIDTH-1:0]  rsp_data_q;
   logic              rsp_err_q;
   logic              rsp_id_q;
`ifdef ROT_SHIFT_OPS_EN
   logic              big_q;
`endif

   logic              w_gnt0, w_gnt1;
   logic [AMT_W-1:0]  w_rot_amt;
   logic [WIDTH-1:0]  w_rot;
   logic [WIDTH-1:0]  w_res;
   logic              w_err;

   // Grants are only offered from IDLE and never while reset is asserted.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (state_q == ST_IDLE && !reset) begin
         if (r0_valid && (!r1_valid || !prio_q)) w_gnt0 = 1'b1;
         else if (r1_valid)                      w_gnt1 = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_gnt0 || w_gnt1) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Right-rotating families rotate left by the two's complement of the amount.
   assign w_rot_amt = (op_q == OP_ROL || op_q == OP_SHL) ? amt_q : AMT_W'(0) - amt_q;

   rot_core #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_core (
      .data_i (data_q),
      .amt_i  (w_rot_amt),
      .data_o (w_rot)
   );

`ifdef ROT_SHIFT_OPS_EN
   logic [WIDTH-1:0] w_mask_r;
   logic [WIDTH-1:0] w_sign;
   assign w_mask_r = {WIDTH{1'b1}} >> amt_q;
   assign w_sign   = {WIDTH{data_q[WIDTH-1]}};
`endif

   always_comb begin
      w_res = '0;
      w_err = 1'b0;
      case (op_q)
         OP_ROL, OP_ROR: w_res = w_rot;
`ifdef ROT_SHIFT_OPS_EN
         OP_SHL:  w_res = big_q ? '0 : (w_rot & ({WIDTH{1'b1}} << amt_q));
         OP_SHR:  w_res = big_q ? '0 : (w_rot & w_mask_r);
         OP_SHRA: w_res = big_q ? w_sign : ((w_rot & w_mask_r) | (w_sign & ~w_mask_r));
`endif
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         prio_q     <= 1'b0;
         op_q       <= '0;
         data_q     <= '0;
         amt_q      <= '0;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         rsp_id_q   <= 1'b0;
`ifdef ROT_SHIFT_OPS_EN
         big_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (w_gnt0 || w_gnt1) begin
            op_q   <= w_gnt1 ? r1_op   : r0_op;
            data_q <= w_gnt1 ? r1_data : r0_data;
            amt_q  <= w_gnt1 ? r1_amt[AMT_W-1:0] : r0_amt[AMT_W-1:0];
            id_q   <= w_gnt1;
            prio_q <= ~w_gnt1;
`ifdef ROT_SHIFT_OPS_EN
            big_q  <= w_gnt1 ? (|r1_amt[WIDTH-1:AMT_W]) : (|r0_amt[WIDTH-1:AMT_W]);
`endif
         end
         if (state_q == ST_EXEC) begin
            rsp_data_q <= w_res;
            rsp_err_q  <= w_err;
            rsp_id_q   <= id_q;
         end
      end
   end

   assign r0_ready  = w_gnt0;
   assign r1_ready  = w_gnt1;
   assign rsp_valid = (state_q == ST_RESP) && !reset;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rot_shift_sched.sv
`default_nettype none
// =============================================================================
// tb_rot_shift_sched : directed table-driven bench for rot_shift_sched.
// Rev 1.0
// =============================================================================
module tb_rot_shift_sched;
   import rot_shift_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [2:0]  r0_op, r1_op;
   logic [31:0] r0_data, r0_amt, r1_data, r1_amt;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0] rsp_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [31:0] data;
      logic [31:0] amt;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[16];

   rot_shift_sched #(.WIDTH(32), .OP_W(3)) dut (
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_data(r0_data), .r0_amt(r0_amt),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_data(r1_data), .r1_amt(r1_amt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic id, input logic [2:0] op, input logic [31:0] d, input logic [31:0] a);
      if (id) begin
         r1_valid = 1'b1; r1_op = op; r1_data = d; r1_amt = a;
      end else begin
         r0_valid = 1'b1; r0_op = op; r0_data = d; r0_amt = a;
      end
   endtask

   // Full transaction: accept in T, check EXEC at T+1 and response at T+2.
   task automatic run_op(input string name, input logic id, input logic [2:0] op,
                         input logic [31:0] d, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
      int n;
      @(negedge clk);
      drive(id, op, d, a);
      #1;
      n = 0;
      while (!(id ? r1_ready : r0_ready) && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk({name, " ready"}, 32'(id ? r1_ready : r0_ready), 32'd1);
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      chk({name, " exec_valid"}, 32'(rsp_valid), 32'd0);
      @(negedge clk); #1;
      chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " rsp_data"}, rsp_data, exp_d);
      chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
      chk({name, " rsp_id"}, 32'(rsp_id), 32'(id));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk({name, " rsp_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_d;
      logic        exp_e;
      int g, r, last, cyc;

      vecs[0]  = '{1'b0, OP_ROL,  32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0};
      vecs[1]  = '{1'b1, OP_ROR,  32'h0000_0001, 32'd4,  32'h1000_0000, 1'b0};
      vecs[2]  = '{1'b0, OP_ROL,  32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0};
      vecs[3]  = '{1'b1, OP_ROR,  32'h0000_0001, 32'd36, 32'h1000_0000, 1'b0};
      vecs[4]  = '{1'b0, OP_ROR,  32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1'b0};
      vecs[5]  = '{1'b1, OP_ROL,  32'h1234_5678, 32'd8,  32'h3456_7812, 1'b0};
      vecs[6]  = '{1'b0, OP_ROL,  32'h0000_0001, 32'd33, 32'h0000_0002, 1'b0};
      vecs[7]  = '{1'b0, OP_SHRA, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0};
      vecs[8]  = '{1'b1, OP_SHR,  32'h8000_0000, 32'd4,  32'h0800_0000, 1'b0};
      vecs[9]  = '{1'b0, OP_SHL,  32'hFFFF_FFFF, 32'd40, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b1, OP_SHL,  32'h0000_000F, 32'd4,  32'h0000_00F0, 1'b0};
      vecs[11] = '{1'b0, OP_SHRA, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0};
      vecs[12] = '{1'b1, OP_SHR,  32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0};
      vecs[13] = '{1'b0, OP_SHRA, 32'h7000_0000, 32'd4,  32'h0700_0000, 1'b0};
      vecs[14] = '{1'b0, 3'd7,    32'h1234_5678, 32'd1,  32'h0000_0000, 1'b1};
      vecs[15] = '{1'b1, 3'd5,    32'hFFFF_FFFF, 32'd0,  32'h0000_0000, 1'b1};

      reset = 1'b1; rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_op = '0; r0_data = '0; r0_amt = '0;
      r1_valid = 1'b1; r1_op = '0; r1_data = '0; r1_amt = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst r0_ready", 32'(r0_ready), 32'd0);
      chk("rst r1_ready", 32'(r1_ready), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_data", rsp_data, 32'd0);
      chk("rst rsp_id", 32'(rsp_id), 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      r0_valid = 1'b0; r1_valid = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         exp_d = vecs[i].exp;
         exp_e = vecs[i].err;
`ifndef ROT_SHIFT_OPS_EN
         if (vecs[i].op > OP_ROR) begin exp_d = '0; exp_e = 1'b1; end
`endif
         run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].amt, exp_d, exp_e);
      end

      // Contention: both requesters valid continuously from reset.
      do_reset();
      drive(1'b0, OP_ROL, 32'h0000_0001, 32'd1);
      drive(1'b1, OP_ROR, 32'h0000_0001, 32'd1);
      rsp_ready = 1'b1;
      g = 0; r = 0; last = 0; cyc = 0;
      while ((g < 4 || r < 4) && cyc < 40) begin
         #1;
         if (r0_ready && r1_ready) chk("cont dual_grant", 32'd1, 32'd0);
         if (r0_ready || r1_ready) begin
            chk("cont grant_id", 32'(r1_ready), 32'(g % 2));
            if (g > 0) chk("cont interval", 32'(cyc - last), 32'd3);
            last = cyc;
            g++;
         end
         if (rsp_valid) begin
            chk("cont rsp_id", 32'(rsp_id), 32'(r % 2));
            chk("cont rsp_data", rsp_data, (r % 2) ? 32'h8000_0000 : 32'h0000_0002);
            r++;
            if (r == 4) begin r0_valid = 1'b0; r1_valid = 1'b0; end
         end
         @(negedge clk);
         cyc++;
      end
      chk("cont grants", 32'(g), 32'd4);
      chk("cont rsps", 32'(r), 32'd4);
      rsp_ready = 1'b0;
      r0_valid = 1'b0; r1_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Backpressure: response held for 5 cycles while r1 waits.
      drive(1'b0, OP_ROL, 32'hA5A5_A5A5, 32'd4);
      #1;
      chk("bp r0_ready", 32'(r0_ready), 32'd1);
      @(negedge clk);
      r0_valid = 1'b0;
      drive(1'b1, OP_ROL, 32'h0000_0001, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp hold_data", rsp_data, 32'h5A5A_5A5A);
         chk("bp no_ready", 32'({r0_ready, r1_ready}), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp release_ready", 32'(r1_ready), 32'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("bp next_grant", 32'(r1_ready), 32'd1);
      chk("bp rsp_drop", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      r1_valid = 1'b0;
      @(negedge clk); #1;
      chk("bp r1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp r1_rsp_data", rsp_data, 32'h0000_0001);
      chk("bp r1_rsp_id", 32'(rsp_id), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset during EXEC: op discarded, outputs cleared.
      drive(1'b0, OP_ROL, 32'h0000_0001, 32'd3);
      #1;
      chk("rexec ready", 32'(r0_ready), 32'd1);
      @(negedge clk);
      r0_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rexec rsp_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      chk("rexec rsp_data", rsp_data, 32'd0);
      chk("rexec rsp_id", 32'(rsp_id), 32'd0);
      chk("rexec rsp_err", 32'(rsp_err), 32'd0);

      // Reset during RESP: rsp_valid drops in the same cycle; prio returns to 0.
      drive(1'b0, OP_ROL, 32'h0000_0001, 32'd2);
      @(negedge clk);
      r0_valid = 1'b0;
      @(negedge clk); #1;
      chk("rresp valid_before", 32'(rsp_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rresp valid_drop", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, OP_ROL, 32'h0000_0001, 32'd5);
      drive(1'b1, OP_ROL, 32'h0000_0001, 32'd6);
      #1;
      chk("rresp prio r0", 32'(r0_ready), 32'd1);
      chk("rresp prio r1", 32'(r1_ready), 32'd0);
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(negedge clk); #1;
      chk("rresp next_data", rsp_data, 32'h0000_0020);
      chk("rresp next_id", 32'(rsp_id), 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
